// File: rtl/lp_serializer_pkg.sv
// Shared types and sizing helpers for the parametrised low-power serializer.
//   state_e         : word-level FSM state (IDLE, SHIFT)
//   beats_per_word  : data beats plus the optional parity beat
//   cnt_width       : beat counter width for a given beat count
package lp_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Beats emitted per word: WIDTH/LANES data beats plus one parity beat when enabled.
  function automatic int unsigned beats_per_word(input int unsigned width,
                                                 input int unsigned lanes,
                                                 input int unsigned parity_en);
    return (width / lanes) + parity_en;
  endfunction

  // Counter width for 0..b-1; b is always >= 2, so this is at least 1.
  function automatic int unsigned cnt_width(input int unsigned b);
    return $clog2(b);
  endfunction

endpackage

// File: rtl/lp_param_serializer_if.sv
// Parallel-in / serial-out bus of the serializer.
//   PAR_IN, IN_VALID, MSB_FIRST : word offered by the datapath
//   IN_READY                    : serializer can take a word this cycle
//   SERIAL_OUT, OUT_VALID, FRAME: beat stream towards the pad/link driver
// master = datapath/link side, slave = serializer.
interface lp_param_serializer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 1
);
  logic [WIDTH-1:0] PAR_IN;
  logic             IN_VALID;
  logic             IN_READY;
  logic             MSB_FIRST;
  logic [LANES-1:0] SERIAL_OUT;
  logic             OUT_VALID;
  logic             FRAME;

  modport master (
    output PAR_IN, IN_VALID, MSB_FIRST,
    input  IN_READY, SERIAL_OUT, OUT_VALID, FRAME
  );

  modport slave (
    input  PAR_IN, IN_VALID, MSB_FIRST,
    output IN_READY, SERIAL_OUT, OUT_VALID, FRAME
  );
endinterface

// File: rtl/lp_ser_lane_shifter.sv
// One serial lane: N-bit shift register, running even-parity accumulator and
// the registered lane output bit.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   load_i        : next beat is data beat 0 of a new word (bits_i[j] = beat j)
//   shift_i       : next beat is the following data beat
//   par_i         : next beat is the parity beat
//   bit_o         : registered lane level (IDLE_LEVEL when no command)
module lp_ser_lane_shifter #(
  parameter int unsigned N          = 16,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [N-1:0] bits_i,
  input  logic         shift_i,
  input  logic         par_i,
  output logic         bit_o
);

  logic [N-1:0] sh_q, sh_d;
  logic         par_q, par_d;
  logic         bit_q, bit_d;

  // Parity accumulates each data bit as it is put on the lane.
  always_comb begin
    sh_d  = sh_q;
    par_d = par_q;
    bit_d = IDLE_LEVEL;
    if (load_i) begin
      bit_d = bits_i[0];
      sh_d  = bits_i >> 1;
      par_d = bits_i[0];
    end else if (shift_i) begin
      bit_d = sh_q[0];
      sh_d  = sh_q >> 1;
      par_d = par_q ^ sh_q[0];
    end else if (par_i) begin
      bit_d = par_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sh_q  <= '0;
      par_q <= 1'b0;
      bit_q <= IDLE_LEVEL;
    end else begin
      sh_q  <= sh_d;
      par_q <= par_d;
      bit_q <= bit_d;
    end
  end

  assign bit_o = bit_q;

endmodule

// File: rtl/lp_param_serializer.sv
// Parametrised handshaked serializer: WIDTH-bit word -> WIDTH/LANES beats on
// LANES lanes, optional even-parity beat, FRAME on beat 0, back-to-back words.
//   CLK   : clock
//   RESET : synchronous active-low reset
//   bus   : lp_param_serializer_if.slave (word in, ready out, beat stream out)
module lp_param_serializer
  import lp_serializer_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned LANES      = 1,
  parameter int unsigned PARITY_EN  = 0,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input logic                  CLK,
  input logic                  RESET,
  lp_param_serializer_if.slave bus
);

  localparam int unsigned N  = WIDTH / LANES;
  localparam int unsigned B  = beats_per_word(WIDTH, LANES, PARITY_EN);
  localparam int unsigned CW = cnt_width(B);
  localparam logic [CW-1:0] LAST_BEAT = CW'(B - 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(N - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic            out_valid_q, out_valid_d;
  logic            frame_q, frame_d;
  logic            in_ready_c, accept_c;
  logic            load_c, shift_c, par_c;
  logic [LANES-1:0] serial_c;

  // Ready depends only on registered state and RESET, never on IN_VALID.
  assign in_ready_c = RESET && ((state_q == IDLE) || (beat_q == LAST_BEAT));
  assign accept_c   = bus.IN_VALID && in_ready_c;

  // State register, beat counter and registered frame flags.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      frame_q     <= frame_d;
    end
  end

  // Next state: an accept always restarts at beat 0, even mid last beat.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    if (accept_c) begin
      state_d = SHIFT;
      beat_d  = '0;
    end else if (state_q == SHIFT) begin
      if (beat_q == LAST_BEAT) begin
        state_d = IDLE;
        beat_d  = '0;
      end else begin
        beat_d = beat_q + CW'(1);
      end
    end
  end

  // Outputs: decide what the next visible beat is.
  always_comb begin
    load_c      = accept_c;
    shift_c     = 1'b0;
    par_c       = 1'b0;
    out_valid_d = accept_c;
    frame_d     = accept_c;
    if (!accept_c && (state_q == SHIFT)) begin
      shift_c     = (beat_q < LAST_DATA);
      par_c       = (PARITY_EN != 0) && (beat_q == LAST_DATA);
      out_valid_d = (beat_q != LAST_BEAT);
    end
  end

  // Lane bit mapping: lane l, data beat j takes one bit of PAR_IN by bit order.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [N-1:0] bits_c;
    for (genvar j = 0; j < N; j++) begin : g_bit
      assign bits_c[j] = bus.MSB_FIRST ? bus.PAR_IN[WIDTH - LANES*(j+1) + l]
                                       : bus.PAR_IN[j*LANES + l];
    end

    lp_ser_lane_shifter #(
      .N          (N),
      .IDLE_LEVEL (IDLE_LEVEL)
    ) u_lane (
      .clk_i   (CLK),
      .rst_ni  (RESET),
      .load_i  (load_c),
      .bits_i  (bits_c),
      .shift_i (shift_c),
      .par_i   (par_c),
      .bit_o   (serial_c[l])
    );
  end

  assign bus.IN_READY   = in_ready_c;
  assign bus.SERIAL_OUT = serial_c;
  assign bus.OUT_VALID  = out_valid_q;
  assign bus.FRAME      = frame_q;

endmodule

// File: tb/tb_lp_param_serializer.sv
// Bench for lp_param_serializer: three configurations driven by one stimulus
// stream (16x1 no parity; 16x4 parity; 16x1 parity idle-high), each checked
// every cycle against a word/beat-list reference model, plus known-answer
// checks on captured beat sequences.
module tb_lp_param_serializer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] par_in;
  logic        msb_first;

  localparam int LN [3] = '{1, 4, 1};
  localparam int PE [3] = '{0, 1, 1};
  localparam int IL [3] = '{0, 0, 1};
  string NAME [3] = '{"a16x1", "b16x4p", "c16x1pi"};

  lp_param_serializer_if #(.WIDTH(16), .LANES(1)) if_a ();
  lp_param_serializer_if #(.WIDTH(16), .LANES(4)) if_b ();
  lp_param_serializer_if #(.WIDTH(16), .LANES(1)) if_c ();

  assign if_a.PAR_IN = par_in;  assign if_a.IN_VALID = in_valid;  assign if_a.MSB_FIRST = msb_first;
  assign if_b.PAR_IN = par_in;  assign if_b.IN_VALID = in_valid;  assign if_b.MSB_FIRST = msb_first;
  assign if_c.PAR_IN = par_in;  assign if_c.IN_VALID = in_valid;  assign if_c.MSB_FIRST = msb_first;

  lp_param_serializer #(.WIDTH(16), .LANES(1), .PARITY_EN(0), .IDLE_LEVEL(1'b0))
    u_a (.CLK(clk), .RESET(rst_n), .bus(if_a));
  lp_param_serializer #(.WIDTH(16), .LANES(4), .PARITY_EN(1), .IDLE_LEVEL(1'b0))
    u_b (.CLK(clk), .RESET(rst_n), .bus(if_b));
  lp_param_serializer #(.WIDTH(16), .LANES(1), .PARITY_EN(1), .IDLE_LEVEL(1'b1))
    u_c (.CLK(clk), .RESET(rst_n), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model: the beat list of the word in flight and which beat is visible (-1 = none).
  logic [3:0]  exp_beat [3][17];
  int          blen [3];
  int          pos  [3];
  logic [31:0] cap  [3];
  int          valid_cnt_a;
  int          frame_cnt_a;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ser_of(input int d);
    case (d)
      0:       return {3'b000, if_a.SERIAL_OUT};
      1:       return if_b.SERIAL_OUT;
      default: return {3'b000, if_c.SERIAL_OUT};
    endcase
  endfunction

  function automatic logic valid_of(input int d);
    case (d)
      0:       return if_a.OUT_VALID;
      1:       return if_b.OUT_VALID;
      default: return if_c.OUT_VALID;
    endcase
  endfunction

  function automatic logic frame_of(input int d);
    case (d)
      0:       return if_a.FRAME;
      1:       return if_b.FRAME;
      default: return if_c.FRAME;
    endcase
  endfunction

  function automatic logic ready_of(input int d);
    case (d)
      0:       return if_a.IN_READY;
      1:       return if_b.IN_READY;
      default: return if_c.IN_READY;
    endcase
  endfunction

  // Beat list straight from the bit-order and parity rules.
  task automatic build(input int d, input logic [15:0] w, input logic msb);
    int         l_n;
    int         n;
    logic [3:0] b;
    logic [3:0] p;
    l_n = LN[d];
    n   = 16 / l_n;
    p   = '0;
    for (int j = 0; j < n; j++) begin
      b = '0;
      for (int l = 0; l < l_n; l++)
        b[l] = msb ? w[16 - l_n*(j+1) + l] : w[j*l_n + l];
      exp_beat[d][j] = b;
      p = p ^ b;
    end
    if (PE[d] != 0) exp_beat[d][n] = p;
    blen[d] = n + PE[d];
  endtask

  // One clock: drive at negedge, check ready, advance model at posedge, check beat.
  task automatic cycle(input logic rst, input logic v, input logic [15:0] w, input logic m);
    logic       rdy [3];
    logic [3:0] exp_ser;
    logic       exp_v;
    logic       exp_f;
    rst_n = rst; in_valid = v; par_in = w; msb_first = m;
    #1;
    for (int d = 0; d < 3; d++) begin
      rdy[d] = rst && ((pos[d] < 0) || (pos[d] == blen[d] - 1));
      check_eq({NAME[d], " ready"}, 32'(ready_of(d)), 32'(rdy[d]));
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (!rst) pos[d] = -1;
      else if (v && rdy[d]) begin
        build(d, w, m);
        pos[d] = 0;
      end else if ((pos[d] >= 0) && (pos[d] < blen[d] - 1)) pos[d] = pos[d] + 1;
      else pos[d] = -1;
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      exp_v = (pos[d] >= 0);
      exp_f = (pos[d] == 0);
      exp_ser = '0;
      if (exp_v) exp_ser = exp_beat[d][pos[d]];
      else for (int l = 0; l < LN[d]; l++) exp_ser[l] = 1'(IL[d]);
      check_eq({NAME[d], " serial"}, 32'(ser_of(d)), 32'(exp_ser));
      check_eq({NAME[d], " out_valid"}, 32'(valid_of(d)), 32'(exp_v));
      check_eq({NAME[d], " frame"}, 32'(frame_of(d)), 32'(exp_f));
      if (valid_of(d)) cap[d] = (cap[d] << LN[d]) | 32'(ser_of(d));
    end
    if (if_a.OUT_VALID) valid_cnt_a++;
    if (if_a.FRAME) frame_cnt_a++;
  endtask

  task automatic clear_caps();
    for (int d = 0; d < 3; d++) cap[d] = '0;
    valid_cnt_a = 0;
    frame_cnt_a = 0;
  endtask

  task automatic one_word(input logic [15:0] w, input logic m);
    clear_caps();
    cycle(1'b1, 1'b1, w, m);
    repeat (18) cycle(1'b1, 1'b0, 16'h0000, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; par_in = '0; msb_first = 1'b0;
    for (int d = 0; d < 3; d++) begin
      pos[d] = -1; blen[d] = 0; cap[d] = '0;
    end
    valid_cnt_a = 0; frame_cnt_a = 0;
    @(negedge clk);
    repeat (3) cycle(1'b0, 1'b0, 16'h0000, 1'b0);

    // Bit order, single-lane parity, idle-high line.
    one_word(16'hC5AF, 1'b0);
    check_eq("a lsb C5AF", cap[0], 32'h0000_F5A3);
    check_eq("a lsb valid cycles", 32'(valid_cnt_a), 32'd16);
    check_eq("c lsb C5AF+par", cap[2], {15'd0, 16'hF5A3, 1'b0});
    one_word(16'hC5AF, 1'b1);
    check_eq("a msb C5AF", cap[0], 32'h0000_C5AF);
    one_word(16'h1234, 1'b0);
    check_eq("b 1234+par", cap[1], 32'h0004_3214);
    one_word(16'h0001, 1'b0);
    check_eq("c 0001+par", cap[2], {15'd0, 16'h8000, 1'b1});

    // Back-to-back words with IN_VALID held high.
    clear_caps();
    repeat (16) cycle(1'b1, 1'b1, 16'hFFFF, 1'b0);
    repeat (16) cycle(1'b1, 1'b1, 16'h0000, 1'b0);
    repeat (18) cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    check_eq("a b2b valid cycles", 32'(valid_cnt_a), 32'd32);
    check_eq("a b2b frames", 32'(frame_cnt_a), 32'd2);
    check_eq("a b2b bits", cap[0], 32'hFFFF_0000);

    // Reset during beat 5 aborts the word; the next word is clean.
    clear_caps();
    cycle(1'b1, 1'b1, 16'hC5AF, 1'b0);
    repeat (5) cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    cycle(1'b0, 1'b1, 16'h0000, 1'b0);
    clear_caps();
    one_word(16'h0F0F, 1'b0);
    check_eq("a after reset 0F0F", cap[0], 32'h0000_F0F0);
    check_eq("a after reset frames", 32'(frame_cnt_a), 32'd1);

    // Randomized traffic, including occasional resets and mid-word input changes.
    repeat (800)
      cycle(1'(($urandom % 40) != 0), 1'(($urandom % 3) != 0), 16'($urandom), 1'($urandom));
    repeat (18) cycle(1'b1, 1'b0, 16'h0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lp_param_serializer.md
Name: lp_param_serializer

Overview:
Parametrised, handshaked successor to the fixed 16:1 low-power serializer. Converts a WIDTH-bit parallel word into WIDTH/LANES beats on LANES serial output lanes, one beat per CLK. Adds selectable bit order, an optional per-lane parity beat, frame marking, and valid/ready flow control so words stream back-to-back without gaps. Sits between the parallel datapath and the pad/link driver.

Parameters:
WIDTH, 16, parallel word width; WIDTH >= 2.
LANES, 1, serial output lanes; WIDTH % LANES == 0 and WIDTH/LANES >= 2.
PARITY_EN, 0, 1 appends one even-parity beat per word.
IDLE_LEVEL, 1'b0, level driven on every lane when no beat is valid.

Ports:
CLK  in  1  clock, all logic on rising edge.
RESET  in  1  synchronous, active-low reset.
PAR_IN  in  WIDTH  parallel word, captured on accept.
IN_VALID  in  1  PAR_IN holds a word.
IN_READY  out  1  block can accept a word this cycle.
MSB_FIRST  in  1  bit-order select, captured with the word on accept.
SERIAL_OUT  out  LANES  current beat, registered.
OUT_VALID  out  1  SERIAL_OUT carries a data or parity beat, registered.
FRAME  out  1  high on first data beat of each word, registered.

Behaviour:
- N = WIDTH/LANES data beats. B = N + PARITY_EN total beats per word.
- Accept happens when IN_VALID && IN_READY at a rising edge.
- FSM states: IDLE and SHIFT.
  - IDLE -> SHIFT on accept.
  - SHIFT -> SHIFT on accept during the last beat.
  - SHIFT -> IDLE at the last beat with no accept.
- Beat counter runs 0..B-1 and wraps to 0 on accept.
- IN_READY = RESET && (state==IDLE || beat==B-1). It is combinational from registered state, with no combinational path from IN_VALID.
- Latency: a word accepted at edge k shows beat 0 on SERIAL_OUT directly after edge k. Beat j is visible after edge k+j.
- FRAME=1 on beat 0 only. OUT_VALID=1 on beats 0..B-1. Back-to-back words give continuous OUT_VALID with no idle cycle.
- LSB-first data beat j, lane l = PAR_IN[j*LANES+l].
- MSB-first data beat j, lane l = PAR_IN[WIDTH-LANES*(j+1)+l].
- Parity beat (PARITY_EN=1) is beat N. Lane l = XOR of all N data bits sent on lane l for that word, i.e. even parity.
- No valid beat: SERIAL_OUT = {LANES{IDLE_LEVEL}}, OUT_VALID=0, FRAME=0.
- MSB_FIRST and PAR_IN are ignored except at accept. Changing them mid-word has no effect.
- Reset:
  - RESET low at an edge: state=IDLE, counter=0, shift and parity registers=0, SERIAL_OUT=IDLE_LEVEL, OUT_VALID=0, FRAME=0.
  - IN_READY=0 while RESET is low.
  - Reset mid-word aborts the word; its remaining beats are never emitted.
  - First edge with RESET high and IN_VALID=1 accepts a word.

Decomposition:
- Package lp_serializer_pkg holds:
  - state enum (IDLE, SHIFT);
  - function beats_per_word(WIDTH, LANES, PARITY_EN);
  - localparam helper for counter width, $clog2(B).
- One sub-module, lp_ser_lane_shifter: one lane's N-bit shift register plus parity accumulator, instantiated LANES times.
- Top holds the FSM, counter, handshake, and lane bit mapping.

Test Plan:
- Scenario 1, bit order (WIDTH=16, LANES=1, PARITY_EN=0):
  - PAR_IN=16'hC5AF, MSB_FIRST=0 -> SERIAL_OUT beats 1111_0101_1010_0011, FRAME on beat 0, OUT_VALID high for exactly 16 cycles.
  - Same word with MSB_FIRST=1 -> beats 1100_0101_1010_1111.
- Scenario 2, multi-lane with parity (WIDTH=16, LANES=4, PARITY_EN=1): PAR_IN=16'h1234, LSB-first -> SERIAL_OUT 4'h4, 4'h3, 4'h2, 4'h1, then parity beat 4'h4. IN_READY high on the parity beat.
- Scenario 3, single-lane parity (LANES=1, PARITY_EN=1): PAR_IN=16'hC5AF -> 16 data beats then parity 0, since popcount is 10. PAR_IN=16'h0001 -> parity 1.
- Scenario 4, back-to-back: IN_VALID held high with 16'hFFFF then 16'h0000 (LANES=1) -> OUT_VALID continuous for 32 cycles, FRAME pulses 16 cycles apart, IN_READY pulses once per word on beat 15.
- Scenario 5, starvation: one word then IN_VALID=0 -> after beat 15, OUT_VALID=0 and SERIAL_OUT=IDLE_LEVEL. With IDLE_LEVEL=1, the line sits at 1.
- Scenario 6, reset mid-word: RESET driven low during beat 5 of 16'hC5AF -> after that edge SERIAL_OUT=IDLE_LEVEL, OUT_VALID=0, IN_READY=0. After release, the next word 16'h0F0F starts with FRAME and a full 16 beats, with no leftover bits from the aborted word.
